softmax: RTL and testbench
==========================

# softmax

Streaming softmax engine over a vector held in on-chip RAM. The vector spans words `start_addr..end_addr`, with two 16-bit lanes per word. Three passes read through three independent read ports: max search, exp-sum, then normalised output. It sits between the activation buffers and the downstream consumer. Exponentials use base-2 fixed-point approximation.

## Interface
- `DATAWIDTH`, 16: lane width; signed Q8.8 input, unsigned Q8.8 output (0x0100 = 1.0)
- `NUM`, 2: lanes per word; fixed at 2
- `ADDRSIZE`, 8: RAM address width
- `clk` in 1: the block's one clock, all logic on its rising edge
- `reset` in 1: synchronous active-high reset
- `init` in 1: synchronous active-high soft clear, identical effect to `reset`
- `start` in 1: one-cycle run request
- `start_addr`, `end_addr` in ADDRSIZE: first and last word, inclusive; sampled at start
- `inp` in DATAWIDTH*NUM: data at `addr`; lane0 = [15:0], lane1 = [31:16]
- `sub0_inp` in DATAWIDTH*NUM: data at `sub0_inp_addr`
- `sub1_inp` in DATAWIDTH*NUM: data at `sub1_inp_addr`
- `addr` out ADDRSIZE: pass-1 read address
- `sub0_inp_addr` out ADDRSIZE: pass-2 read address
- `sub1_inp_addr` out ADDRSIZE: pass-3 read address
- `outp0`, `outp1` out DATAWIDTH: lane0/lane1 softmax result, registered
- `done` out 1: run complete

## Operation
- RAM reads are combinational: data is valid in the same cycle as its address.
- **States:** IDLE, MAX, SUM, LOG, OUT, DONE.
- **IDLE/DONE + start:**
  - go to MAX.
  - `addr`←`start_addr`; max←0x8000; sum←0; `done`←0.
  - `start` is ignored in every other state.
- **MAX:**
  - max←signed max(max, lane0, lane1).
  - If `addr`==`end_addr`: go to SUM and set `sub0_inp_addr`←`start_addr`. Otherwise `addr`++, wrapping modulo 2^ADDRSIZE.
- **SUM:**
  - Per lane: d = x−max (17-bit, ≤0); t = (d·0x0171)>>>8, where 0x0171 is log2(e) in Q8.8.
  - sum += e2(t0)+e2(t1). sum is DATAWIDTH+ADDRSIZE+2 bits.
  - Advance and exit as in MAX, to LOG.
- **LOG (1 cycle):**
  - p = index of the sum's MSB.
  - L = ((p−8)<<8) | the 8 bits directly below the MSB, zero-filled.
  - L is Q8.8 and ≥0, since sum ≥1.0.
  - Set `sub1_inp_addr`←`start_addr`; go to OUT.
- **OUT:**
  - outp_k ← e2(t_k−L), with t_k computed as in SUM from `sub1_inp`.
  - On `end_addr`, go to DONE with `done`←1.
- **e2(t) for Q8.8 t≤0:**
  - n = −(t>>>8); f = t[7:0].
  - Result = (256+f)>>n.
  - If n≥16 or t < −16.0, the result is 0.
  - This is a linear 2^f approximation.
- **Reset or init:**
  - Any state goes to IDLE.
  - All addresses, outp0/1 and `done` become 0.
  - max becomes 0x8000 and sum becomes 0.
  - Mid-run reset aborts the run with no residual output.
- **Address outputs:** hold their last value outside their own pass.
- **Boundaries:**
  - `start_addr`==`end_addr`: one word per pass.
  - `start_addr`>`end_addr`: the counter wraps through the top of the address space.

## Timing
- N = words in the run. Cycle 0 is the edge that samples `start`.
- MAX occupies cycles 1..N, SUM N+1..2N, LOG 2N+1, OUT 2N+2..3N+1.
- Output word i appears on outp0/1 one cycle after its `sub1_inp_addr`, at cycle 2N+3+i.
- `done` rises with the last output word (cycle 3N+2) and holds until the next start, reset or init.
- Total latency 3N+2 cycles. There is no separate valid strobe; the consumer counts from `start`.

## Structure
- Shared package: DATAWIDTH, NUM, ADDRSIZE, LOG2E=16'h0171, MAX_INIT=16'h8000, state encoding.
- One sub-module `exp2_q88`: combinational e2(t) with 17-bit signed input and 16-bit output. Instantiated for both lanes; the same instance serves SUM and OUT through a mux on the input operand.
- Log2 is an inline priority encoder in the top.

## Test plan
- **Four zeros:** words 0..1 = 0 → L=0x0200; all outputs 0x0040; `done` at cycle 8.
- **Single word (start=end=0), lane0=0x0100, lane1=0x0000:**
  - sum=0x0163, L=0x0063.
  - outp0=0x00CE, outp1=0x004B; `done` at cycle 5.
- **Extreme spread:** lane0=0x7F00, lane1=0x8000 → outp0=0x0100, outp1=0x0000.
- **Address sequencing, start=3, end=7:**
  - `addr` 3..7 on cycles 1..5; `sub0_inp_addr` 3..7 on cycles 6..10.
  - `sub1_inp_addr` 3..7 on cycles 12..16; `done` at 17.
- **Reset mid-run:** assert `reset` during SUM → next cycle all outputs 0 and IDLE. A fresh start then reproduces the full result.
- **Wrap and ignored start:**
  - start=0xFF, end=0x01 → 3 words (0xFF, 0x00, 0x01).
  - A `start` pulse during MAX has no effect.

Source files
------------

// File: rtl/softmax_pkg.sv
// Shared constants, state encoding and helpers for the softmax engine.
package softmax_pkg;

  localparam int DATAWIDTH = 16;
  localparam int NUM       = 2;
  localparam int ADDRSIZE  = 8;

  // Running exp-sum width: one lane result per word-lane plus headroom.
  localparam int SUMW = DATAWIDTH + ADDRSIZE + 2;
  // Bits needed to hold an MSB index of the sum.
  localparam int PBW  = $clog2(SUMW);
  // Exponent operand width (signed Q8.8 difference, one extra bit).
  localparam int TW   = DATAWIDTH + 1;
  // Product width for difference * log2(e).
  localparam int PW   = TW + 10;

  localparam logic [DATAWIDTH-1:0] LOG2E    = 16'h0171;
  localparam logic [DATAWIDTH-1:0] MAX_INIT = 16'h8000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MAX,
    S_SUM,
    S_LOG,
    S_OUT,
    S_DONE
  } state_t;

  // Clamp a wide exponent operand into the TW-bit e2 domain (t <= 0).
  // Anything below the representable range is far past the point where e2
  // returns zero, so pinning it at the most negative value is exact.
  function automatic logic signed [TW-1:0] sat_t(input logic signed [PW:0] v);
    if (!v[PW]) return '0;
    if (!(&v[PW:TW-1])) return {1'b1, {(TW-1){1'b0}}};
    return v[TW-1:0];
  endfunction

endpackage

// File: rtl/softmax_exp2_q88.sv
// Base-2 exponential for signed Q8.8 t <= 0, linear mantissa approximation.
module exp2_q88
  import softmax_pkg::*;
(
  input  logic signed [TW-1:0]        t,
  output logic        [DATAWIDTH-1:0] y
);

  logic signed [9:0]          n;
  logic        [DATAWIDTH-1:0] mant;

  // Split t into integer shift and fractional mantissa, then shift down.
  always_comb begin
    n    = -{t[TW-1], t[TW-1:8]};
    mant = DATAWIDTH'(256) + DATAWIDTH'(t[7:0]);
    // Positive t is outside the domain; the caller clamps it to zero.
    if (n < 0 || n >= 10'sd16 || t < -17'sd4096)
      y = '0;
    else
      y = mant >> n[3:0];
  end

endmodule

// File: rtl/softmax.sv
// Three-pass streaming softmax over a two-lane Q8.8 vector held in RAM.
module softmax
  import softmax_pkg::*;
#(
  parameter int DATAWIDTH = 16,
  parameter int NUM       = 2,
  parameter int ADDRSIZE  = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      init,
  input  logic                      start,
  input  logic [ADDRSIZE-1:0]       start_addr,
  input  logic [ADDRSIZE-1:0]       end_addr,
  input  logic [DATAWIDTH*NUM-1:0]  inp,
  input  logic [DATAWIDTH*NUM-1:0]  sub0_inp,
  input  logic [DATAWIDTH*NUM-1:0]  sub1_inp,
  output logic [ADDRSIZE-1:0]       addr,
  output logic [ADDRSIZE-1:0]       sub0_inp_addr,
  output logic [ADDRSIZE-1:0]       sub1_inp_addr,
  output logic [DATAWIDTH-1:0]      outp0,
  output logic [DATAWIDTH-1:0]      outp1,
  output logic                      done
);

  state_t state, state_nx;

  logic [ADDRSIZE-1:0]         start_r, end_r;
  logic signed [DATAWIDTH-1:0] max_r, max_nx;
  logic [SUMW-1:0]             sum_r;
  logic [DATAWIDTH-1:0]        l_r, l_nx;

  logic signed [DATAWIDTH-1:0] m0, m1;
  logic signed [DATAWIDTH-1:0] x0, x1;
  logic signed [TW-1:0]        d0, d1;
  logic signed [PW-1:0]        tq0, tq1;
  logic [DATAWIDTH-1:0]        lsub;
  logic signed [TW-1:0]        e_in0, e_in1;
  logic [DATAWIDTH-1:0]        e_out0, e_out1;

  logic [PBW-1:0]              msb;
  logic [7:0]                  frac;

  // Running signed maximum over both lanes of the pass-1 word.
  always_comb begin
    m0     = inp[DATAWIDTH-1:0];
    m1     = inp[2*DATAWIDTH-1:DATAWIDTH];
    max_nx = max_r;
    if (m0 > max_nx) max_nx = m0;
    if (m1 > max_nx) max_nx = m1;
  end

  // Shared exponent operand: pass-2 data during SUM, pass-3 data minus L in OUT.
  always_comb begin
    if (state == S_OUT) begin
      x0   = sub1_inp[DATAWIDTH-1:0];
      x1   = sub1_inp[2*DATAWIDTH-1:DATAWIDTH];
      lsub = l_r;
    end else begin
      x0   = sub0_inp[DATAWIDTH-1:0];
      x1   = sub0_inp[2*DATAWIDTH-1:DATAWIDTH];
      lsub = '0;
    end
    d0    = {x0[DATAWIDTH-1], x0} - {max_r[DATAWIDTH-1], max_r};
    d1    = {x1[DATAWIDTH-1], x1} - {max_r[DATAWIDTH-1], max_r};
    tq0   = ($signed(PW'(d0)) * $signed(PW'(LOG2E))) >>> 8;
    tq1   = ($signed(PW'(d1)) * $signed(PW'(LOG2E))) >>> 8;
    // Subtraction done wide and clamped so a huge spread cannot wrap positive.
    e_in0 = sat_t({tq0[PW-1], tq0} - {{(PW+1-DATAWIDTH){1'b0}}, lsub});
    e_in1 = sat_t({tq1[PW-1], tq1} - {{(PW+1-DATAWIDTH){1'b0}}, lsub});
  end

  exp2_q88 u_exp0 (
    .t (e_in0),
    .y (e_out0)
  );

  exp2_q88 u_exp1 (
    .t (e_in1),
    .y (e_out1)
  );

  // Log2 of the sum: MSB index gives the integer part, next 8 bits the fraction.
  always_comb begin
    msb = '0;
    for (int unsigned i = 0; i < SUMW; i++) begin
      if (sum_r[i]) msb = PBW'(i);
    end
    if (msb >= PBW'(8))
      frac = 8'(sum_r >> (msb - PBW'(8)));
    else
      frac = 8'(sum_r << (PBW'(8) - msb));
    l_nx = {8'(msb) - 8'd8, frac};
  end

  // Pass sequencing: each pass ends when its own address reaches end_addr.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE, S_DONE: if (start) state_nx = S_MAX;
      S_MAX:          if (addr == end_r) state_nx = S_SUM;
      S_SUM:          if (sub0_inp_addr == end_r) state_nx = S_LOG;
      S_LOG:          state_nx = S_OUT;
      S_OUT:          if (sub1_inp_addr == end_r) state_nx = S_DONE;
      default:        state_nx = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset || init) state <= S_IDLE;
    else               state <= state_nx;
  end

  // Datapath registers: addresses, max, sum, L and the result lanes.
  always_ff @(posedge clk) begin
    if (reset || init) begin
      addr          <= '0;
      sub0_inp_addr <= '0;
      sub1_inp_addr <= '0;
      outp0         <= '0;
      outp1         <= '0;
      done          <= 1'b0;
      max_r         <= MAX_INIT;
      sum_r         <= '0;
      l_r           <= '0;
      start_r       <= '0;
      end_r         <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            addr    <= start_addr;
            start_r <= start_addr;
            end_r   <= end_addr;
            max_r   <= MAX_INIT;
            sum_r   <= '0;
            done    <= 1'b0;
          end
        end
        S_MAX: begin
          max_r <= max_nx;
          if (addr == end_r) sub0_inp_addr <= start_r;
          else               addr <= addr + ADDRSIZE'(1);
        end
        S_SUM: begin
          sum_r <= sum_r + SUMW'(e_out0) + SUMW'(e_out1);
          if (sub0_inp_addr != end_r) sub0_inp_addr <= sub0_inp_addr + ADDRSIZE'(1);
        end
        S_LOG: begin
          l_r           <= l_nx;
          sub1_inp_addr <= start_r;
        end
        S_OUT: begin
          outp0 <= e_out0;
          outp1 <= e_out1;
          if (sub1_inp_addr == end_r) done <= 1'b1;
          else                        sub1_inp_addr <= sub1_inp_addr + ADDRSIZE'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_softmax.sv
// Directed-vector bench for the softmax engine with a combinational RAM model.
module tb_softmax;

  logic        clk = 1'b0;
  logic        reset, init, start;
  logic [7:0]  start_addr, end_addr;
  logic [31:0] inp, sub0_inp, sub1_inp;
  logic [7:0]  addr, sub0_inp_addr, sub1_inp_addr;
  logic [15:0] outp0, outp1;
  logic        done;

  logic [31:0] mem [256];

  assign inp      = mem[addr];
  assign sub0_inp = mem[sub0_inp_addr];
  assign sub1_inp = mem[sub1_inp_addr];

  always #5 clk = ~clk;

  softmax #(.DATAWIDTH(16), .NUM(2), .ADDRSIZE(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .init          (init),
    .start         (start),
    .start_addr    (start_addr),
    .end_addr      (end_addr),
    .inp           (inp),
    .sub0_inp      (sub0_inp),
    .sub1_inp      (sub1_inp),
    .addr          (addr),
    .sub0_inp_addr (sub0_inp_addr),
    .sub1_inp_addr (sub1_inp_addr),
    .outp0         (outp0),
    .outp1         (outp1),
    .done          (done)
  );

  typedef struct {
    logic [7:0]        sa;
    logic [7:0]        ea;
    int unsigned       n;
    logic [4:0][31:0]  w;
    logic [4:0][15:0]  e0;
    logic [4:0][15:0]  e1;
  } vec_t;

  vec_t        tbl [5];
  int unsigned n_chk = 0;
  int unsigned n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " addr"},  32'(addr), 32'h0);
    chk({tag, " sub0"},  32'(sub0_inp_addr), 32'h0);
    chk({tag, " sub1"},  32'(sub1_inp_addr), 32'h0);
    chk({tag, " outp0"}, 32'(outp0), 32'h0);
    chk({tag, " outp1"}, 32'(outp1), 32'h0);
    chk({tag, " done"},  32'(done), 32'h0);
  endtask

  task automatic load(input vec_t v);
    for (int unsigned i = 0; i < v.n; i++) mem[8'(v.sa + i)] = v.w[i];
  endtask

  // Start pulse sampled on edge 0; returns #1 after that edge (cycle 1).
  task automatic kick(input logic [7:0] sa, input logic [7:0] ea);
    @(negedge clk);
    start_addr = sa;
    end_addr   = ea;
    start      = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Full run with per-cycle address, output and done checks.
  task automatic run(input int idx, input vec_t v, input bit glitch);
    int unsigned nn;
    nn = v.n;
    load(v);
    kick(v.sa, v.ea);
    for (int unsigned c = 1; c <= 3*nn + 3; c++) begin
      if (c <= nn)
        chk($sformatf("v%0d c%0d addr", idx, c), 32'(addr), 32'(8'(v.sa + c - 1)));
      if (c >= nn + 1 && c <= 2*nn)
        chk($sformatf("v%0d c%0d sub0", idx, c), 32'(sub0_inp_addr), 32'(8'(v.sa + c - nn - 1)));
      if (c >= 2*nn + 2 && c <= 3*nn + 1)
        chk($sformatf("v%0d c%0d sub1", idx, c), 32'(sub1_inp_addr), 32'(8'(v.sa + c - 2*nn - 2)));
      if (c >= 2*nn + 3 && c <= 3*nn + 2) begin
        chk($sformatf("v%0d c%0d outp0", idx, c), 32'(outp0), 32'(v.e0[c - 2*nn - 3]));
        chk($sformatf("v%0d c%0d outp1", idx, c), 32'(outp1), 32'(v.e1[c - 2*nn - 3]));
      end
      chk($sformatf("v%0d c%0d done", idx, c), 32'(done), 32'(c >= 3*nn + 2));
      if (glitch && c == 2) begin
        start      = 1'b1;
        start_addr = 8'h40;
        end_addr   = 8'h40;
      end
      if (glitch && c == 3) start = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset      = 1'b1;
    init       = 1'b0;
    start      = 1'b0;
    start_addr = '0;
    end_addr   = '0;
    for (int i = 0; i < 256; i++) mem[i] = '0;

    tbl[0] = '{sa:8'h00, ea:8'h01, n:2, w:'0,
               e0:{5{16'h0040}}, e1:{5{16'h0040}}};
    tbl[1] = '{sa:8'h00, ea:8'h00, n:1, w:{128'h0, 32'h0000_0100},
               e0:{64'h0, 16'h00CE}, e1:{64'h0, 16'h004B}};
    tbl[2] = '{sa:8'h05, ea:8'h05, n:1, w:{128'h0, 32'h8000_7F00},
               e0:{64'h0, 16'h0100}, e1:{64'h0, 16'h0000}};
    tbl[3] = '{sa:8'h03, ea:8'h07, n:5, w:'0,
               e0:{5{16'h001C}}, e1:{5{16'h001C}}};
    tbl[4] = '{sa:8'hFF, ea:8'h01, n:3, w:{128'h0, 32'h0000_0100},
               e0:{32'h0, 16'h0023, 16'h0023, 16'h0062},
               e1:{32'h0, 16'h0023, 16'h0023, 16'h0023}};

    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    reset = 1'b0;

    // Table runs; the wrap case also carries a stray start during MAX.
    for (int i = 0; i < 5; i++) run(i, tbl[i], i == 4);

    // Soft clear after a completed run.
    @(negedge clk);
    init = 1'b1;
    @(posedge clk);
    #1;
    init = 1'b0;
    chk_all_zero("init");

    // Reset in the middle of SUM, then a clean rerun.
    run(5, tbl[1], 1'b0);
    load(tbl[0]);
    kick(8'h00, 8'h01);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk_all_zero("midrst");
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("midrst idle");
    run(6, tbl[0], 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
    $finish;
  end

endmodule
